// File: rtl/mipi_csi_raw_depacker.sv
// CSI-2 RAW10/RAW12/RAW14 depacker: gathers the 4-byte payload words of one
// packet into a small byte buffer and emits four LSB-aligned pixels whenever
// a complete packing group is present.
module mipi_csi_raw_depacker #(
  parameter int PIXEL_W = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 data_valid_i,
  input  logic [31:0]          data_i,
  input  logic [2:0]           packet_type_i,
  input  logic [15:0]          packet_length_i,
  output logic                 pixel_valid_o,
  output logic [4*PIXEL_W-1:0] pixel_data_o,
  output logic                 packet_done_o,
  output logic                 unsupported_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DROP   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [79:0]          byteBuf_q, byteBuf_d;
  logic [3:0]           count_q, count_d;
  logic [15:0]          remaining_q, remaining_d;
  logic [2:0]           pktType_q, pktType_d;
  logic                 pixelValid_q, pixelValid_d;
  logic [4*PIXEL_W-1:0] pixelData_q, pixelData_d;
  logic                 packetDone_q, packetDone_d;
  logic                 unsupported_q, unsupported_d;

  logic                 typeSupported;
  logic                 startPkt;
  logic                 takeWord;
  logic [2:0]           curType;
  logic [15:0]          curRemaining;
  logic [2:0]           appendBytes;
  logic [31:0]          wordMask;
  logic [79:0]          appended;
  logic [3:0]           newCount;
  logic [3:0]           groupSize;
  logic [4*PIXEL_W-1:0] unpacked;
  logic [7:0]           b [7];
  logic [23:0]          lsbs14;
  logic [13:0]          raw [4];

  // On the first word the packet header comes straight from the inputs.
  assign typeSupported = (packet_type_i == 3'd3) || (packet_type_i == 3'd4) ||
                         (packet_type_i == 3'd5);
  assign startPkt      = (state_q == IDLE) && data_valid_i && typeSupported;
  assign takeWord      = startPkt || ((state_q == ACTIVE) && data_valid_i);
  assign curType       = (state_q == IDLE) ? packet_type_i : pktType_q;
  assign curRemaining  = (state_q == IDLE) ? packet_length_i : remaining_q;

  // Append the in-length bytes of the current word behind the residue.
  always_comb begin
    appendBytes = (curRemaining >= 16'd4) ? 3'd4 : curRemaining[2:0];
    case (appendBytes)
      3'd0:    wordMask = 32'h0000_0000;
      3'd1:    wordMask = 32'h0000_00FF;
      3'd2:    wordMask = 32'h0000_FFFF;
      3'd3:    wordMask = 32'h00FF_FFFF;
      default: wordMask = 32'hFFFF_FFFF;
    endcase
    appended = byteBuf_q | ({48'b0, data_i & wordMask} << {count_q, 3'b000});
    newCount = count_q + {1'b0, appendBytes};
    case (curType)
      3'd3:    groupSize = 4'd5;
      3'd4:    groupSize = 4'd6;
      default: groupSize = 4'd7;
    endcase
  end

  // Unpack the oldest group of the appended buffer into four pixel lanes.
  always_comb begin
    for (int i = 0; i < 7; i++) begin
      b[i] = appended[8*i +: 8];
    end
    lsbs14 = {b[6], b[5], b[4]};
    case (curType)
      3'd3: begin
        raw[0] = {4'b0, b[0], b[4][1:0]};
        raw[1] = {4'b0, b[1], b[4][3:2]};
        raw[2] = {4'b0, b[2], b[4][5:4]};
        raw[3] = {4'b0, b[3], b[4][7:6]};
      end
      3'd4: begin
        raw[0] = {2'b0, b[0], b[2][3:0]};
        raw[1] = {2'b0, b[1], b[2][7:4]};
        raw[2] = {2'b0, b[3], b[5][3:0]};
        raw[3] = {2'b0, b[4], b[5][7:4]};
      end
      default: begin
        raw[0] = {b[0], lsbs14[5:0]};
        raw[1] = {b[1], lsbs14[11:6]};
        raw[2] = {b[2], lsbs14[17:12]};
        raw[3] = {b[3], lsbs14[23:18]};
      end
    endcase
    unpacked = '0;
    for (int k = 0; k < 4; k++) begin
      unpacked[k*PIXEL_W +: 14] = raw[k];
    end
  end

  // Packet state machine plus buffer update and output decisions.
  always_comb begin
    state_d       = state_q;
    byteBuf_d     = byteBuf_q;
    count_d       = count_q;
    remaining_d   = remaining_q;
    pktType_d     = pktType_q;
    pixelValid_d  = 1'b0;
    pixelData_d   = pixelData_q;
    packetDone_d  = 1'b0;
    unsupported_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_valid_i) begin
          if (typeSupported) begin
            state_d = ACTIVE;
          end else begin
            state_d       = DROP;
            unsupported_d = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (!data_valid_i) begin
          state_d      = IDLE;
          packetDone_d = 1'b1;
          byteBuf_d    = '0;
          count_d      = '0;
          remaining_d  = '0;
          pktType_d    = '0;
        end
      end
      DROP: begin
        if (!data_valid_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (takeWord) begin
      pktType_d   = curType;
      remaining_d = curRemaining - {13'b0, appendBytes};
      if (newCount >= groupSize) begin
        pixelValid_d = 1'b1;
        pixelData_d  = unpacked;
        byteBuf_d    = appended >> {groupSize, 3'b000};
        count_d      = newCount - groupSize;
      end else begin
        byteBuf_d = appended;
        count_d   = newCount;
      end
    end
  end

  // State and output registers; reset abandons any group in flight.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= IDLE;
      byteBuf_q     <= '0;
      count_q       <= '0;
      remaining_q   <= '0;
      pktType_q     <= '0;
      pixelValid_q  <= 1'b0;
      pixelData_q   <= '0;
      packetDone_q  <= 1'b0;
      unsupported_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      byteBuf_q     <= byteBuf_d;
      count_q       <= count_d;
      remaining_q   <= remaining_d;
      pktType_q     <= pktType_d;
      pixelValid_q  <= pixelValid_d;
      pixelData_q   <= pixelData_d;
      packetDone_q  <= packetDone_d;
      unsupported_q <= unsupported_d;
    end
  end

  assign pixel_valid_o = pixelValid_q;
  assign pixel_data_o  = pixelData_q;
  assign packet_done_o = packetDone_q;
  assign unsupported_o = unsupported_q;

endmodule

// File: tb/tb_mipi_csi_raw_depacker.sv
// Bench for mipi_csi_raw_depacker: directed packets from the test plan plus
// randomized packets, compared cycle by cycle against a byte-level model.
module tb_mipi_csi_raw_depacker;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        data_valid_i;
  logic [31:0] data_i;
  logic [2:0]  packet_type_i;
  logic [15:0] packet_length_i;
  logic        pixel_valid_o;
  logic [63:0] pixel_data_o;
  logic        packet_done_o;
  logic        unsupported_o;

  int          checks = 0;
  int          failures = 0;

  logic [7:0]  pktBytes [64];
  logic        expValid;
  logic        expDone;
  logic        expUnsup;
  logic [63:0] expData;
  logic [63:0] lastPixels;

  mipi_csi_raw_depacker #(.PIXEL_W(16)) dut (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .data_valid_i    (data_valid_i),
    .data_i          (data_i),
    .packet_type_i   (packet_type_i),
    .packet_length_i (packet_length_i),
    .pixel_valid_o   (pixel_valid_o),
    .pixel_data_o    (pixel_data_o),
    .packet_done_o   (packet_done_o),
    .unsupported_o   (unsupported_o)
  );

  // Free-running byte clock.
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Four pixels of the group starting at byte offset base, from the packing rules.
  function automatic logic [63:0] modelGroup(input int ptype, input int base);
    int b [7];
    int p [4];
    int lsbs;
    logic [63:0] r;
    for (int i = 0; i < 7; i++) b[i] = int'(pktBytes[base + i]);
    if (ptype == 3) begin
      for (int k = 0; k < 4; k++) p[k] = b[k] * 4 + ((b[4] >> (2 * k)) % 4);
    end else if (ptype == 4) begin
      p[0] = b[0] * 16 + b[2] % 16;
      p[1] = b[1] * 16 + b[2] / 16;
      p[2] = b[3] * 16 + b[5] % 16;
      p[3] = b[4] * 16 + b[5] / 16;
    end else begin
      lsbs = b[4] + b[5] * 256 + b[6] * 65536;
      for (int k = 0; k < 4; k++) p[k] = b[k] * 64 + ((lsbs >> (6 * k)) % 64);
    end
    r = '0;
    for (int k = 0; k < 4; k++) r[16*k +: 16] = 16'(p[k]);
    return r;
  endfunction

  // Wait for the falling edge and compare all outputs with the pending expectation.
  task automatic sampleOutputs();
    @(negedge clk_i);
    checkOutput("pixel_valid", {63'b0, pixel_valid_o}, {63'b0, expValid});
    checkOutput("pixel_data", pixel_data_o, expData);
    checkOutput("packet_done", {63'b0, packet_done_o}, {63'b0, expDone});
    checkOutput("unsupported", {63'b0, unsupported_o}, {63'b0, expUnsup});
  endtask

  // Drive one packet of nwords words from pktBytes, then one low cycle.
  // abortAfter > 0 asserts reset after that word instead of ending normally.
  task automatic applyStimulus(input int ptype, input int plen, input int nwords,
                               input int abortAfter);
    bit supported;
    int g;
    int acc;
    int groups;
    int prevGroups;
    supported  = (ptype == 3) || (ptype == 4) || (ptype == 5);
    g          = (ptype == 3) ? 5 : (ptype == 4) ? 6 : 7;
    prevGroups = 0;
    for (int w = 1; w <= nwords; w++) begin
      sampleOutputs();
      data_valid_i = 1'b1;
      data_i = {pktBytes[4*w-1], pktBytes[4*w-2], pktBytes[4*w-3], pktBytes[4*w-4]};
      if (w == 1) begin
        packet_type_i   = 3'(ptype);
        packet_length_i = 16'(plen);
      end else begin
        packet_type_i   = 3'($urandom);
        packet_length_i = 16'($urandom);
      end
      expValid = 1'b0;
      expDone  = 1'b0;
      expUnsup = !supported && (w == 1);
      if (supported) begin
        acc    = (4 * w < plen) ? 4 * w : plen;
        groups = acc / g;
        if (groups > prevGroups) begin
          expValid   = 1'b1;
          lastPixels = modelGroup(ptype, (groups - 1) * g);
        end
        prevGroups = groups;
      end
      expData = lastPixels;
      if (w == abortAfter) begin
        sampleOutputs();
        reset_n_i    = 1'b0;
        data_valid_i = 1'b0;
        #1;
        checkOutput("rst_pixel_valid", {63'b0, pixel_valid_o}, 64'd0);
        checkOutput("rst_pixel_data", pixel_data_o, 64'd0);
        checkOutput("rst_packet_done", {63'b0, packet_done_o}, 64'd0);
        checkOutput("rst_unsupported", {63'b0, unsupported_o}, 64'd0);
        lastPixels = '0;
        expValid   = 1'b0;
        expData    = '0;
        expDone    = 1'b0;
        expUnsup   = 1'b0;
        sampleOutputs();
        reset_n_i = 1'b1;
        return;
      end
    end
    sampleOutputs();
    data_valid_i    = 1'b0;
    data_i          = $urandom;
    packet_type_i   = 3'($urandom);
    packet_length_i = 16'($urandom);
    expValid = 1'b0;
    expData  = lastPixels;
    expDone  = supported;
    expUnsup = 1'b0;
  endtask

  task automatic fillRandom();
    for (int i = 0; i < 64; i++) pktBytes[i] = 8'($urandom);
  endtask

  // Directed packets followed by a randomized run.
  initial begin
    int ptype;
    reset_n_i       = 1'b0;
    data_valid_i    = 1'b0;
    data_i          = '0;
    packet_type_i   = '0;
    packet_length_i = '0;
    lastPixels      = '0;
    expValid        = 1'b0;
    expData         = '0;
    expDone         = 1'b0;
    expUnsup        = 1'b0;
    sampleOutputs();
    sampleOutputs();
    reset_n_i = 1'b1;

    for (int i = 0; i < 64; i++) pktBytes[i] = 8'h00;
    pktBytes[0] = 8'h01; pktBytes[1] = 8'h02; pktBytes[2] = 8'h03;
    pktBytes[3] = 8'h04; pktBytes[4] = 8'hE4;
    applyStimulus(3, 5, 2, 0);

    for (int i = 0; i < 64; i++) pktBytes[i] = (i % 3 == 0) ? 8'hAB : (i % 3 == 1) ? 8'hCD : 8'h21;
    applyStimulus(4, 12, 3, 0);

    for (int i = 0; i < 64; i++) pktBytes[i] = 8'(i + 1);
    applyStimulus(5, 28, 7, 0);

    fillRandom();
    applyStimulus(3, 7, 4, 0);

    fillRandom();
    applyStimulus(2, 12, 3, 0);
    fillRandom();
    applyStimulus(4, 12, 3, 0);

    fillRandom();
    applyStimulus(5, 28, 7, 3);
    fillRandom();
    applyStimulus(5, 28, 7, 0);

    fillRandom();
    applyStimulus(3, 0, 2, 0);

    for (int n = 0; n < 40; n++) begin
      fillRandom();
      if ($urandom_range(0, 7) == 0) begin
        ptype = int'($urandom_range(0, 4));
        if (ptype >= 3) ptype = ptype + 3;
      end else begin
        ptype = int'($urandom_range(3, 5));
      end
      applyStimulus(ptype, int'($urandom_range(0, 40)), int'($urandom_range(1, 12)), 0);
    end

    sampleOutputs();
    expDone = 1'b0;
    sampleOutputs();
    sampleOutputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
